// File: rtl/uart_tx_serializer_if.sv
// Signal bundle between the TX FIFO read port, the UART transmit serializer
// and the serial pin. The serializer connects through the slave modport.
interface uart_tx_serializer_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_r_data;
    logic             tx;
    logic             busy;
    logic             done;

    // FIFO / pin side: supplies FIFO status and data, observes the line.
    modport master (
        output fifo_empty,
        output fifo_r_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  done
    );

    // Serializer side.
    modport slave (
        input  fifo_empty,
        input  fifo_r_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops a word from the TX FIFO and sends start, WIDTH data
// bits LSB first, optional parity (macro UART_TX_PARITY_EN) and one stop bit on tx.
module uart_tx_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

    if (CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q;
    logic             baud_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        // The baud counter free-runs through every on-line state and wraps per bit.
        if (state_q == START || state_q == DATA || state_q == STOP
`ifdef UART_TX_PARITY_EN
            || state_q == PARITY
`endif
           ) begin
            baud_d = baud_end ? '0 : baud_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) state_d = POP;
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = bus.fifo_r_data;
                baud_d  = '0;
`ifdef UART_TX_PARITY_EN
                parity_d = (^bus.fifo_r_data) ^ (PARITY_ODD != 0);
`endif
                state_d = START;
            end
            START: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_end) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx is computed from the next state so the registered pin changes on the
    // same edge as the state, with no decode glitches reaching the line.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only; the
    // datapath registers are reset as well so a frame aborted by rst leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= (state_q != IDLE);
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_rd_en = (state_q == POP);
    assign bus.done       = (state_q == STOP) && baud_end;
endmodule
